// File: rtl/dmx_transmitter.sv
// DMX512 transmitter: break, mark-after-break, start code 0x00, then up to 512 slots read from an external buffer.
// Define DMX_TX_MTBS_EN to insert a MTBS_CLKS mark between consecutive slots.
module dmx_transmitter #(
    parameter int CLK_FREQ  = 20_000_000,
    parameter int BAUD_RATE = 250_000,
    parameter int BREAK_US  = 100,
    parameter int MAB_US    = 12,
    parameter int MTBS_CLKS = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_frame,
    input  logic [9:0] slot_count,
    output logic       rd_en,
    output logic [8:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       DMX_Output_Signal,
    output logic       tx_enable,
    output logic       busy,
    output logic       frame_done
);

    localparam int     BIT_TIME   = CLK_FREQ / BAUD_RATE;
    localparam longint BREAK_L    = longint'(CLK_FREQ) * BREAK_US / 1_000_000;
    localparam longint MAB_L      = longint'(CLK_FREQ) * MAB_US / 1_000_000;
    localparam int     BREAK_CLKS = int'(BREAK_L);
    localparam int     MAB_CLKS   = int'(MAB_L);
    // One counter serves every timed phase, so size it for the sum of all of them.
    localparam int     CNT_W      = $clog2(BREAK_CLKS + MAB_CLKS + 2 * BIT_TIME + MTBS_CLKS + 1);

    localparam logic [CNT_W-1:0] BRK_END  = CNT_W'(BREAK_CLKS - 1);
    localparam logic [CNT_W-1:0] MAB_END  = CNT_W'(MAB_CLKS - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BIT_TIME - 1);
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(2 * BIT_TIME - 1);
`ifdef DMX_TX_MTBS_EN
    localparam logic [CNT_W-1:0] MTBS_END = CNT_W'(MTBS_CLKS - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREAK,
        ST_MAB,
        ST_START_BIT,
        ST_DATA_BITS,
        ST_STOP_BITS,
        ST_DONE
`ifdef DMX_TX_MTBS_EN
        , ST_MTBS
`endif
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [9:0]       r_slot, w_slot_nxt;
    logic [9:0]       r_count, w_count_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_line, w_line_nxt;
    logic             r_rd_en, w_rd_en_nxt;
    logic [8:0]       r_rd_addr, w_rd_addr_nxt;
    logic             r_cap;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             w_last;

    assign w_last = (r_slot == r_count);

    // Every output is computed from the next state and registered, so the line never glitches.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_bit_nxt     = r_bit;
        w_slot_nxt    = r_slot;
        w_count_nxt   = r_count;
        w_shift_nxt   = r_shift;
        w_line_nxt    = r_line;
        w_rd_en_nxt   = 1'b0;
        w_rd_addr_nxt = r_rd_addr;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt  = '0;
                w_line_nxt = 1'b1;
                if (start_frame) begin
                    w_state_nxt = ST_BREAK;
                    w_slot_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_shift_nxt = 8'h00;
                    w_count_nxt = (slot_count > 10'd512) ? 10'd512 : slot_count;
                    w_line_nxt  = 1'b0;
                end
            end
            ST_BREAK: begin
                if (r_cnt == BRK_END) begin
                    w_state_nxt = ST_MAB;
                    w_cnt_nxt   = '0;
                    w_line_nxt  = 1'b1;
                end
            end
            ST_MAB: begin
                if (r_cnt == MAB_END) begin
                    w_state_nxt = ST_START_BIT;
                    w_cnt_nxt   = '0;
                    w_line_nxt  = 1'b0;
                end
            end
            ST_START_BIT: begin
                if (r_cnt == BIT_END) begin
                    w_state_nxt = ST_DATA_BITS;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_line_nxt  = r_shift[0];
                end
            end
            ST_DATA_BITS: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt   = ST_STOP_BITS;
                        w_line_nxt    = 1'b1;
                        w_rd_en_nxt   = !w_last;
                        w_rd_addr_nxt = r_slot[8:0];
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = r_shift >> 1;
                        w_line_nxt  = r_shift[1];
                    end
                end
            end
            ST_STOP_BITS: begin
                // Buffer answers one cycle after the strobe issued on the first stop-bit cycle.
                if (r_cap) w_shift_nxt = rd_data;
                if (r_cnt == STOP_END) begin
                    w_cnt_nxt = '0;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                        w_line_nxt  = 1'b1;
                    end else begin
                        w_slot_nxt = r_slot + 10'd1;
`ifdef DMX_TX_MTBS_EN
                        w_state_nxt = ST_MTBS;
                        w_line_nxt  = 1'b1;
`else
                        w_state_nxt = ST_START_BIT;
                        w_line_nxt  = 1'b0;
`endif
                    end
                end
            end
`ifdef DMX_TX_MTBS_EN
            ST_MTBS: begin
                if (r_cnt == MTBS_END) begin
                    w_state_nxt = ST_START_BIT;
                    w_cnt_nxt   = '0;
                    w_line_nxt  = 1'b0;
                end
            end
`endif
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_line_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_line_nxt  = 1'b1;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_slot    <= '0;
            r_count   <= '0;
            r_shift   <= '0;
            r_line    <= 1'b1;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_cap     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_slot    <= w_slot_nxt;
            r_count   <= w_count_nxt;
            r_shift   <= w_shift_nxt;
            r_line    <= w_line_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_cap     <= r_rd_en;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign rd_en             = r_rd_en;
    assign rd_addr           = r_rd_addr;
    assign DMX_Output_Signal = r_line;
    assign tx_enable         = r_busy;
    assign busy              = r_busy;
    assign frame_done        = r_done;

endmodule

// File: tb/tb_dmx_transmitter.sv
// Bench for dmx_transmitter: a default-timing instance plus a fast-timing instance for the long frames,
// both checked cycle by cycle against a line waveform built from the DMX framing rules.
module tb_dmx_transmitter;

    localparam int D_BT = 80, D_BRK = 2000, D_MAB = 240, D_MT = 40;
    localparam int F_BT = 4,  F_BRK = 100,  F_MAB = 12,  F_MT = 4;
`ifdef DMX_TX_MTBS_EN
    localparam bit MTBS_ON = 1'b1;
`else
    localparam bit MTBS_ON = 1'b0;
`endif
    localparam int D_GAP = MTBS_ON ? D_MT : 0;
    localparam int F_GAP = MTBS_ON ? F_MT : 0;

    typedef struct {
        bit fast;
        int cnt;
        int inj;
        int exp_rd;
        int exp_busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [9:0] slot_count = '0;
    logic [7:0] mem [0:511];

    logic       d_start, d_rd_en, d_line, d_txen, d_busy, d_done;
    logic [8:0] d_rd_addr;
    logic [7:0] d_rd_data = '0;
    logic       f_start, f_rd_en, f_line, f_txen, f_busy, f_done;
    logic [8:0] f_rd_addr;
    logic [7:0] f_rd_data = '0;
    logic       m_rd_en, m_line, m_txen, m_busy, m_done;
    logic [8:0] m_rd_addr;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    assign d_start   = start && !sel;
    assign f_start   = start && sel;
    assign m_rd_en   = sel ? f_rd_en   : d_rd_en;
    assign m_rd_addr = sel ? f_rd_addr : d_rd_addr;
    assign m_line    = sel ? f_line    : d_line;
    assign m_txen    = sel ? f_txen    : d_txen;
    assign m_busy    = sel ? f_busy    : d_busy;
    assign m_done    = sel ? f_done    : d_done;

    // Slot buffer: data appears one cycle after the read strobe.
    always @(posedge clk) if (d_rd_en) d_rd_data <= mem[d_rd_addr];
    always @(posedge clk) if (f_rd_en) f_rd_data <= mem[f_rd_addr];

    dmx_transmitter u_dut (
        .clk(clk), .rst(rst), .start_frame(d_start), .slot_count(slot_count),
        .rd_en(d_rd_en), .rd_addr(d_rd_addr), .rd_data(d_rd_data),
        .DMX_Output_Signal(d_line), .tx_enable(d_txen), .busy(d_busy), .frame_done(d_done)
    );

    dmx_transmitter #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(250_000), .BREAK_US(100), .MAB_US(12), .MTBS_CLKS(F_MT)
    ) u_fast (
        .clk(clk), .rst(rst), .start_frame(f_start), .slot_count(slot_count),
        .rd_en(f_rd_en), .rd_addr(f_rd_addr), .rd_data(f_rd_data),
        .DMX_Output_Signal(f_line), .tx_enable(f_txen), .busy(f_busy), .frame_done(f_done)
    );

    task automatic check(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; starts a frame there and returns at the negedge of the first idle cycle after it.
    task automatic run_frame(input bit fast, input int cnt, input int inj, output int rd_cnt, output int busy_w);
        bit         q[$];
        int         n, bt, brk, mab, mt, L, exp_line;
        int         line_err = 0, busy_err = 0, txe_err = 0, addr_err = 0;
        int         done_cnt = 0, done_at = -1, bad_at = -1;
        logic [7:0] b;
        n   = (cnt > 512) ? 512 : cnt;
        bt  = fast ? F_BT  : D_BT;
        brk = fast ? F_BRK : D_BRK;
        mab = fast ? F_MAB : D_MAB;
        mt  = fast ? F_MT  : D_MT;
        repeat (brk) q.push_back(1'b0);
        repeat (mab) q.push_back(1'b1);
        for (int s = 0; s <= n; s++) begin
            b = (s == 0) ? 8'h00 : mem[s-1];
            repeat (bt) q.push_back(1'b0);
            for (int k = 0; k < 8; k++) repeat (bt) q.push_back(b[k]);
            repeat (2 * bt) q.push_back(1'b1);
            if (MTBS_ON && s < n) repeat (mt) q.push_back(1'b1);
        end
        L = q.size();
        sel        = fast;
        slot_count = 10'(cnt);
        start      = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        rd_cnt = 0;
        busy_w = 0;
        for (int i = 0; i <= L + 1; i++) begin
            exp_line = (i < L) ? int'(q[i]) : 1;
            if (int'(m_line) != exp_line) begin
                line_err++;
                if (bad_at < 0) bad_at = i;
            end
            if (m_busy !== (i <= L)) busy_err++;
            if (m_busy === 1'b1) busy_w++;
            if (m_txen !== (i <= L)) txe_err++;
            if (m_done === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
            if (m_rd_en === 1'b1) begin
                if (m_rd_addr !== 9'(rd_cnt)) addr_err++;
                rd_cnt++;
            end
            start = (i == inj);
            if (i == inj) slot_count = 10'd7;
            if (i <= L) @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("line bad cycles (first at %0d)", bad_at), line_err, 0);
        check("busy waveform errors", busy_err, 0);
        check("tx_enable waveform errors", txe_err, 0);
        check("frame_done pulses", done_cnt, 1);
        check("frame_done cycle", done_at, L);
        check("rd_addr order errors", addr_err, 0);
    endtask

    initial begin
        vec_t tbl[5];
        int   rc, bw, n, bad;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hA5;
        mem[1] = 8'h01;
        mem[2] = 8'hFF;
        tbl[0] = '{0, 0,   -1, 0,   D_BRK + D_MAB + 880 + 1};
        tbl[1] = '{0, 3,   -1, 3,   D_BRK + D_MAB + 4 * 880 + 3 * D_GAP + 1};
        tbl[2] = '{1, 600, -1, 512, F_BRK + F_MAB + 513 * 44 + 512 * F_GAP + 1};
        tbl[3] = '{0, 3,   D_BRK + D_MAB + 880 + 80 + 100, 3, D_BRK + D_MAB + 4 * 880 + 3 * D_GAP + 1};
        tbl[4] = '{1, 1,   -1, 1,   F_BRK + F_MAB + 2 * 44 + F_GAP + 1};

        repeat (3) @(negedge clk);
        check("reset line", int'(d_line & f_line), 1);
        check("reset busy", int'(d_busy | f_busy), 0);
        check("reset tx_enable", int'(d_txen | f_txen), 0);
        check("reset frame_done", int'(d_done | f_done), 0);
        check("reset rd_en", int'(d_rd_en | f_rd_en), 0);
        check("reset rd_addr", int'(d_rd_addr | f_rd_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_frame(tbl[v].fast, tbl[v].cnt, tbl[v].inj, rc, bw);
            check($sformatf("vec%0d rd_en pulses", v), rc, tbl[v].exp_rd);
            check($sformatf("vec%0d busy width", v), bw, tbl[v].exp_busy);
        end

        // Reset during break: abort at once, no frame_done, then a clean frame.
        sel        = 1'b0;
        slot_count = 10'd3;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(negedge clk);
        check("in break line", int'(d_line), 0);
        check("in break busy", int'(d_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort line", int'(d_line), 1);
        check("abort busy", int'(d_busy), 0);
        check("abort tx_enable", int'(d_txen), 0);
        check("abort frame_done", int'(d_done), 0);
        rst = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (d_done !== 1'b0 || d_busy !== 1'b0 || d_line !== 1'b1) bad++;
        end
        check("post-abort idle errors", bad, 0);
        run_frame(0, 3, -1, rc, bw);
        check("post-abort rd_en pulses", rc, 3);
        check("post-abort busy width", bw, D_BRK + D_MAB + 4 * 880 + 3 * D_GAP + 1);

        // Randomized frames, run back to back.
        repeat (6) begin
            for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
            n = int'($urandom_range(0, 40));
            run_frame(1, n, -1, rc, bw);
            check($sformatf("rand fast n=%0d rd_en pulses", n), rc, n);
            check($sformatf("rand fast n=%0d busy width", n), bw, F_BRK + F_MAB + (n + 1) * 11 * F_BT + n * F_GAP + 1);
        end
        repeat (2) begin
            for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
            n = int'($urandom_range(0, 2));
            run_frame(0, n, -1, rc, bw);
            check($sformatf("rand dflt n=%0d rd_en pulses", n), rc, n);
            check($sformatf("rand dflt n=%0d busy width", n), bw, D_BRK + D_MAB + (n + 1) * 11 * D_BT + n * D_GAP + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/dmx_transmitter.md
DMX_TRANSMITTER -- requirements
Module: dmx_transmitter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 20_000_000, system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 250_000, DMX bit rate; BIT_TIME = CLK_FREQ/BAUD_RATE (80 clk).
REQ-003 SHALL have parameter BREAK_US, default 100, break length in us; BREAK_CLKS = CLK_FREQ*BREAK_US/1_000_000 (2000 clk).
REQ-004 SHALL have parameter MAB_US, default 12, mark-after-break in us; MAB_CLKS = 240 clk.
REQ-005 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start_frame  input  1  one-cycle request to send one frame.
REQ-008 SHALL have port slot_count  input  10  number of data slots after start code, 0..512.
REQ-009 SHALL have port rd_en  output  1  one-cycle slot buffer read strobe.
REQ-010 SHALL have port rd_addr  output  9  slot index 0..511 (slot n+1 at address n).
REQ-011 SHALL have port rd_data  input  8  slot byte, valid exactly one cycle after rd_en.
REQ-012 SHALL have port DMX_Output_Signal  output  1  serial line, 1 = mark/idle.
REQ-013 SHALL have port tx_enable  output  1  RS-485 driver enable, high while busy.
REQ-014 SHALL have port busy  output  1  high from accepted start_frame until frame_done.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-016 SHALL accept start_frame only in IDLE; ignored while busy; slot_count latched on acceptance, values >512 clamped to 512.
REQ-017 SHALL implement states IDLE, BREAK, MAB, START_BIT, DATA_BITS, STOP_BITS, DONE; IDLE->BREAK on accepted start_frame.
REQ-018 SHALL drive line 0 for exactly BREAK_CLKS in BREAK, then 1 for exactly MAB_CLKS in MAB.
REQ-019 SHALL send each slot as 1 start bit (0), 8 data bits LSB first, 2 stop bits (1), each exactly BIT_TIME clocks; 11*BIT_TIME per slot (880 clk).
REQ-020 SHALL send start code 0x00 as slot 0 without reading the buffer.
REQ-021 SHALL pulse rd_en with rd_addr = next slot index on the first cycle of STOP_BITS of the preceding slot; SHALL capture rd_data on the following cycle.
REQ-022 SHALL, after last slot's second stop bit, enter DONE for one cycle: frame_done=1, busy and tx_enable deassert the next cycle, return to IDLE.
REQ-023 SHALL, with slot_count=0, send only the start code and issue no rd_en.
REQ-024 SHALL hold DMX_Output_Signal=1 in IDLE and DONE; line SHALL be registered (no glitches).
REQ-025 SHALL accept start_frame on the cycle after DONE (back-to-back frames allowed).

Reset
REQ-026 SHALL, while rst=1, set state IDLE, DMX_Output_Signal=1, tx_enable=0, busy=0, frame_done=0, rd_en=0, rd_addr=0, all counters 0.
REQ-027 SHALL, on rst asserted mid-frame, abort immediately on the next edge with no frame_done; line returns to mark.

Configuration
REQ-028 SHALL, when macro DMX_TX_MTBS_EN is defined, insert state MTBS after each slot except the last, holding line 1 for parameter MTBS_CLKS (default 40) clocks; without it, slots are back-to-back and MTBS_CLKS unused.

Verification
REQ-029 SHALL verify: reset, start_frame, slot_count=3, buffer {0xA5,0x01,0xFF} -> 2000 clk low, 240 clk high, slots 0x00,0xA5,0x01,0xFF decoded LSB-first, frame_done after 240+4*880 clk beyond break.
REQ-030 SHALL verify: slot_count=0 -> start code only, zero rd_en pulses, busy width 2000+240+880+1 clk.
REQ-031 SHALL verify: slot_count=600 -> exactly 512 rd_en pulses, rd_addr 0..511 in order.
REQ-032 SHALL verify: start_frame pulsed during DATA_BITS -> ignored, frame unchanged, single frame_done.
REQ-033 SHALL verify: rst asserted during BREAK of a frame -> next cycle line=1, busy=0, no frame_done; a new start_frame then produces a full frame.
REQ-034 SHALL verify: with DMX_TX_MTBS_EN, slot_count=2 -> 40 clk mark between slots 0/1 and 1/2, none after slot 2.
